// File: rtl/if_id_stage.sv
// IF/ID pipeline register: pairs IMEM words with their fetch PC, absorbs decode stalls
// with a one-entry skid buffer and inserts NOP bubbles on flush. Optional macro: IF_ID_IMM_DECODE_EN.
module if_id_stage #(
    parameter logic [31:0] NOP_INSN = 32'h0000_0013,
    parameter int          PC_W     = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [PC_W-1:0] PC_IN,
    input  logic [31:0]     IR_IN,
    input  logic            STALL,
    input  logic            FLUSH,
    output logic            FETCH_EN,
    output logic            OUT_VALID,
    output logic [PC_W-1:0] OUT_PC,
    output logic [PC_W-1:0] OUT_PC4,
    output logic [31:0]     OUT_IR,
    output logic [6:0]      OUT_OPCODE,
    output logic [4:0]      OUT_RD,
    output logic [4:0]      OUT_RS1,
    output logic [4:0]      OUT_RS2,
    output logic [31:0]     OUT_IMM
);
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] a_pc_q, a_pc_d;
    logic            a_v_q, a_v_d;
    logic [31:0]     s_ir_q, s_ir_d;
    logic            valid_q, valid_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc4_q, pc4_d;
    logic [31:0]     ir_q, ir_d;
    logic            fetch_en_s;
    logic            load_s;
    logic [31:0]     load_word_s;

    // A flush must fetch the redirect target even while decode is stalled.
    assign fetch_en_s = ~STALL | FLUSH;
    assign FETCH_EN   = fetch_en_s;

    // Address-phase register: remembers which PC the word on IR_IN belongs to.
    always_comb begin
        if (fetch_en_s) begin
            a_pc_d = PC_IN;
            a_v_d  = ~FLUSH;
        end else begin
            a_pc_d = a_pc_q;
            a_v_d  = a_v_q;
        end
    end

    // Skid FSM: selects when IF/ID loads and whether from IMEM or the skid word.
    always_comb begin
        state_d     = state_q;
        s_ir_d      = s_ir_q;
        load_s      = 1'b0;
        load_word_s = IR_IN;
        if (FLUSH) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (STALL) begin
                        // IMEM output is only good for one cycle, so capture it now.
                        s_ir_d  = IR_IN;
                        state_d = ST_HOLD;
                    end else begin
                        load_s      = 1'b1;
                        load_word_s = IR_IN;
                    end
                end
                ST_HOLD: begin
                    if (STALL) begin
                        state_d = ST_HOLD;
                    end else begin
                        load_s      = 1'b1;
                        load_word_s = s_ir_q;
                        state_d     = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // IF/ID register next state: bubble on flush, load on release, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        ir_d    = ir_q;
        if (FLUSH) begin
            valid_d = 1'b0;
            ir_d    = NOP_INSN;
        end else if (load_s) begin
            valid_d = a_v_q;
            pc_d    = a_pc_q;
            pc4_d   = a_pc_q + PC_W'(32'd4);
            ir_d    = a_v_q ? load_word_s : NOP_INSN;
        end else begin
            valid_d = valid_q;
            ir_d    = ir_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_RUN;
            a_pc_q  <= '0;
            a_v_q   <= 1'b0;
            s_ir_q  <= NOP_INSN;
            valid_q <= 1'b0;
            pc_q    <= '0;
            pc4_q   <= PC_W'(32'd4);
            ir_q    <= NOP_INSN;
        end else begin
            state_q <= state_d;
            a_pc_q  <= a_pc_d;
            a_v_q   <= a_v_d;
            s_ir_q  <= s_ir_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            ir_q    <= ir_d;
        end
    end

    assign OUT_VALID  = valid_q;
    assign OUT_PC     = pc_q;
    assign OUT_PC4    = pc4_q;
    assign OUT_IR     = ir_q;
    assign OUT_OPCODE = ir_q[6:0];
    assign OUT_RD     = ir_q[11:7];
    assign OUT_RS1    = ir_q[19:15];
    assign OUT_RS2    = ir_q[24:20];

`ifdef IF_ID_IMM_DECODE_EN
    function automatic logic [31:0] imm_decode(input logic [31:0] ir);
        logic [31:0] imm;
        case (ir[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: imm = {{20{ir[31]}}, ir[31:20]};
            7'b0100011: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            7'b1100011: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            7'b0110111, 7'b0010111: imm = {ir[31:12], 12'h000};
            7'b1101111: imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

    logic [31:0] imm_q, imm_d;

    // Immediate tracks whatever word IF/ID is about to hold.
    always_comb begin
        imm_d = imm_decode(ir_d);
    end

    // Immediate register, reset to the NOP's immediate.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            imm_q <= 32'h0000_0000;
        end else begin
            imm_q <= imm_d;
        end
    end

    assign OUT_IMM = imm_q;
`else
    assign OUT_IMM = 32'h0000_0000;
`endif

endmodule
